// File: rtl/fw_boot_loader.sv
// ============================================================================
// Module   : fw_boot_loader
// Brief    : Streams a firmware image into memory at LOAD_BASE, writes the
//            6502 reset vector, then releases the CPU from reset.
//            Optional macro BOOT_CHECKSUM_EN: last byte is an 8-bit checksum.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fw_boot_loader #(
    parameter int                    ADDR_WIDTH     = 16,
    parameter int                    REG_WIDTH      = 8,
    parameter logic [ADDR_WIDTH-1:0] LOAD_BASE      = 16'h0600,
    parameter int                    MAX_SIZE       = 1024,
    parameter logic [ADDR_WIDTH-1:0] RESET_VEC_ADDR = 16'hFFFC,
    parameter int                    RELEASE_DELAY  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  fw_valid,
    input  logic [REG_WIDTH-1:0]  fw_data,
    input  logic                  fw_last,
    output logic                  fw_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [REG_WIDTH-1:0]  mem_din,
    output logic                  bus_grant,
    output logic                  cpu_reset_n,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH-1:0] byte_count
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_VEC_LO = 3'd2;
    localparam logic [2:0] S_VEC_HI = 3'd3;
    localparam logic [2:0] S_HOLD   = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;
    localparam logic [2:0] S_ERR    = 3'd6;

    localparam int                    c_DLY_W    = (RELEASE_DELAY > 1) ? $clog2(RELEASE_DELAY) : 1;
    localparam logic [c_DLY_W-1:0]    c_DLY_LAST = c_DLY_W'(RELEASE_DELAY - 1);
    localparam logic [ADDR_WIDTH-1:0] c_MAX_CNT  = ADDR_WIDTH'(MAX_SIZE);
    localparam logic [REG_WIDTH-1:0]  c_BASE_LO  = REG_WIDTH'(LOAD_BASE);
    localparam logic [REG_WIDTH-1:0]  c_BASE_HI  = REG_WIDTH'(LOAD_BASE >> REG_WIDTH);

    logic [2:0]            r_state;
    logic [c_DLY_W-1:0]    r_dly;
    logic                  r_mem_we;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [REG_WIDTH-1:0]  r_mem_din;
    logic                  r_bus_grant;
    logic                  r_cpu_reset_n;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_error;
    logic [ADDR_WIDTH-1:0] r_byte_count;

    logic                  w_hs;
    logic [ADDR_WIDTH-1:0] w_count_nxt;
    logic [ADDR_WIDTH-1:0] w_load_addr;

    assign w_hs        = fw_valid && (r_state == S_LOAD);
    assign w_count_nxt = r_byte_count + ADDR_WIDTH'(1);
    assign w_load_addr = LOAD_BASE + r_byte_count;

`ifdef BOOT_CHECKSUM_EN
    logic [REG_WIDTH-1:0] r_sum;
    logic [REG_WIDTH-1:0] w_sum_chk;

    assign w_sum_chk = r_sum + fw_data;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_dly         <= '0;
            r_mem_we      <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_din     <= '0;
            r_bus_grant   <= 1'b0;
            r_cpu_reset_n <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_error       <= 1'b0;
            r_byte_count  <= '0;
`ifdef BOOT_CHECKSUM_EN
            r_sum         <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE, S_DONE, S_ERR: begin
                    r_mem_we    <= 1'b0;
                    r_bus_grant <= 1'b0;
                    if (start) begin
                        r_state       <= S_LOAD;
                        r_bus_grant   <= 1'b1;
                        r_busy        <= 1'b1;
                        r_done        <= 1'b0;
                        r_error       <= 1'b0;
                        r_cpu_reset_n <= 1'b0;
                        r_byte_count  <= '0;
`ifdef BOOT_CHECKSUM_EN
                        r_sum         <= '0;
`endif
                    end
                end

                S_LOAD: begin
                    r_mem_we <= 1'b0;
                    if (w_hs) begin
`ifdef BOOT_CHECKSUM_EN
                        if (fw_last) begin
                            // Checksum byte is consumed but never written.
                            if (w_sum_chk == '0) begin
                                r_state <= S_VEC_LO;
                            end else begin
                                r_state     <= S_ERR;
                                r_bus_grant <= 1'b0;
                                r_busy      <= 1'b0;
                                r_error     <= 1'b1;
                            end
                        end else begin
                            r_mem_we     <= 1'b1;
                            r_mem_addr   <= w_load_addr;
                            r_mem_din    <= fw_data;
                            r_byte_count <= w_count_nxt;
                            r_sum        <= w_sum_chk;
                            if (w_count_nxt == c_MAX_CNT) begin
                                r_state <= S_ERR;
                                r_busy  <= 1'b0;
                                r_error <= 1'b1;
                            end
                        end
`else
                        r_mem_we     <= 1'b1;
                        r_mem_addr   <= w_load_addr;
                        r_mem_din    <= fw_data;
                        r_byte_count <= w_count_nxt;
                        if (fw_last) begin
                            r_state <= S_VEC_LO;
                        end else if (w_count_nxt == c_MAX_CNT) begin
                            // Grant stays up one more cycle so the overflowing byte lands.
                            r_state <= S_ERR;
                            r_busy  <= 1'b0;
                            r_error <= 1'b1;
                        end
`endif
                    end
                end

                S_VEC_LO: begin
                    r_mem_we   <= 1'b1;
                    r_mem_addr <= RESET_VEC_ADDR;
                    r_mem_din  <= c_BASE_LO;
                    r_state    <= S_VEC_HI;
                end

                S_VEC_HI: begin
                    r_mem_we   <= 1'b1;
                    r_mem_addr <= RESET_VEC_ADDR + ADDR_WIDTH'(1);
                    r_mem_din  <= c_BASE_HI;
                    r_dly      <= '0;
                    r_state    <= S_HOLD;
                end

                S_HOLD: begin
                    r_mem_we    <= 1'b0;
                    r_bus_grant <= 1'b0;
                    if (r_dly == c_DLY_LAST) begin
                        r_state       <= S_DONE;
                        r_cpu_reset_n <= 1'b1;
                        r_busy        <= 1'b0;
                        r_done        <= 1'b1;
                    end else begin
                        r_dly <= r_dly + c_DLY_W'(1);
                    end
                end

                default: begin
                    r_state  <= S_IDLE;
                    r_mem_we <= 1'b0;
                end
            endcase
        end
    end

    assign fw_ready    = (r_state == S_LOAD);
    assign mem_we      = r_mem_we;
    assign mem_addr    = r_mem_addr;
    assign mem_din     = r_mem_din;
    assign bus_grant   = r_bus_grant;
    assign cpu_reset_n = r_cpu_reset_n;
    assign busy        = r_busy;
    assign done        = r_done;
    assign error       = r_error;
    assign byte_count  = r_byte_count;

endmodule

`default_nettype wire

// File: tb/tb_fw_boot_loader.sv
// ============================================================================
// Module   : tb_fw_boot_loader
// Brief    : Directed self-checking bench for fw_boot_loader (MAX_SIZE=6).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_fw_boot_loader;

    localparam int c_MAX = 6;
    localparam int c_DLY = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        fw_valid = 1'b0;
    logic [7:0]  fw_data = 8'h00;
    logic        fw_last = 1'b0;
    logic        fw_ready, mem_we, bus_grant, cpu_reset_n, busy, done, error;
    logic [15:0] mem_addr, byte_count;
    logic [7:0]  mem_din;

    always #5 clk = ~clk;

    fw_boot_loader #(
        .MAX_SIZE      (c_MAX),
        .RELEASE_DELAY (c_DLY)
    ) u_dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .fw_valid    (fw_valid),
        .fw_data     (fw_data),
        .fw_last     (fw_last),
        .fw_ready    (fw_ready),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_din     (mem_din),
        .bus_grant   (bus_grant),
        .cpu_reset_n (cpu_reset_n),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .byte_count  (byte_count)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Bus monitor: memory model, write counters, handshake-to-write and release timing
    logic [7:0] mem [0:65535];
    int  cyc = 0, last_cyc = 0, rel_cyc = 0;
    int  nwr = 0, nvec = 0, bad_we = 0;
    logic hs_q = 1'b0, rn_q = 1'b0;

    always @(posedge clk) begin
        cyc  <= cyc + 1;
        hs_q <= fw_valid && fw_ready;
        if (fw_valid && fw_ready && fw_last) last_cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        rn_q <= cpu_reset_n;
        if (cpu_reset_n && !rn_q) rel_cyc <= cyc;
        if (mem_we) begin
            mem[mem_addr] <= mem_din;
            nwr <= nwr + 1;
            if (mem_addr == 16'hFFFC || mem_addr == 16'hFFFD) nvec <= nvec + 1;
            else if (!hs_q) bad_we <= bad_we + 1;
        end
    end

    logic [7:0] img [0:15];
    int wr0, vec0, bwe0;

    task automatic snap();
        wr0 = nwr; vec0 = nvec; bwe0 = bad_we;
    endtask

    task automatic do_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    // Offer k bytes of an n-byte image; optional idle cycles carrying start=poke
    task automatic send(input int n, input int k, input bit toggle, input bit poke);
        int i = 0;
        int guard = 0;
        bit ph = 1'b0;
        while (i < k && guard < 100) begin
            @(negedge clk);
            guard++;
            if (!fw_ready) break;
            if (toggle && ph) begin
                fw_valid = 1'b0; fw_last = 1'b0; start = poke;
            end else begin
                fw_valid = 1'b1; fw_data = img[i]; fw_last = (i == n - 1); start = 1'b0;
                i++;
            end
            ph = !ph;
        end
        @(negedge clk);
        fw_valid = 1'b0; fw_last = 1'b0; start = 1'b0;
    endtask

    task automatic wait_end(input string t);
        int g = 0;
        while (!(done || error) && g < 60) begin
            @(negedge clk);
            g++;
        end
        chk({t, "_timeout"}, (g < 60), 1);
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic check_load(input string t, input int npay);
        for (int i = 0; i < npay; i++) chk({t, "_mem"}, mem[16'h0600 + i], img[i]);
        chk({t, "_vec_lo"}, mem[16'hFFFC], 8'h00);
        chk({t, "_vec_hi"}, mem[16'hFFFD], 8'h06);
        chk({t, "_nwr"}, nwr - wr0, npay + 2);
        chk({t, "_nvec"}, nvec - vec0, 2);
        chk({t, "_we_align"}, bad_we - bwe0, 0);
        chk({t, "_count"}, byte_count, npay);
        chk({t, "_flags"}, {done, error, busy, bus_grant, cpu_reset_n}, 5'b10001);
        chk({t, "_release"}, rel_cyc - last_cyc, c_DLY + 2);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_flags", {mem_we, bus_grant, cpu_reset_n, busy, done, error, fw_ready}, 7'b0);
        chk("rst_addr", mem_addr, 16'h0000);
        chk("rst_din", mem_din, 8'h00);
        chk("rst_count", byte_count, 16'h0000);
        reset = 1'b0;

        // fw_valid while IDLE is ignored
        snap();
        fw_valid = 1'b1; fw_data = 8'h55;
        repeat (4) @(negedge clk);
        fw_valid = 1'b0;
        @(negedge clk);
        chk("idle_nwr", nwr - wr0, 0);
        chk("idle_state", {busy, fw_ready, byte_count}, 18'h0);

`ifdef BOOT_CHECKSUM_EN
        img[0] = 8'h10; img[1] = 8'h20; img[2] = 8'hD0;
        snap();
        do_start();
        send(3, 3, 1'b0, 1'b0);
        wait_end("ck_good");
        check_load("ck_good", 2);

        img[2] = 8'hD1;
        snap();
        do_start();
        send(3, 3, 1'b0, 1'b0);
        wait_end("ck_bad");
        chk("ck_bad_flags", {done, error, busy, cpu_reset_n}, 4'b0100);
        chk("ck_bad_nvec", nvec - vec0, 0);
        chk("ck_bad_nwr", nwr - wr0, 2);
        chk("ck_bad_count", byte_count, 2);
`else
        img[0] = 8'hA9; img[1] = 8'h01; img[2] = 8'h8D; img[3] = 8'h00; img[4] = 8'h02;
        snap();
        do_start();
        chk("a_start", {bus_grant, busy, cpu_reset_n, fw_ready}, 4'b1101);
        send(5, 5, 1'b0, 1'b0);
        wait_end("a");
        check_load("a", 5);

        // Restart from DONE, valid toggled, start poked during LOAD
        snap();
        do_start();
        chk("b_restart", {cpu_reset_n, busy, done, bus_grant}, 4'b0101);
        chk("b_count0", byte_count, 0);
        send(5, 5, 1'b1, 1'b1);
        wait_end("b");
        check_load("b", 5);

        // Image of exactly MAX_SIZE bytes is legal
        for (int i = 0; i < 6; i++) img[i] = 8'h11 + 8'(i);
        snap();
        do_start();
        send(6, 6, 1'b0, 1'b0);
        wait_end("max");
        check_load("max", 6);

        // Overflow: 8-byte image with MAX_SIZE=6
        for (int i = 0; i < 8; i++) img[i] = 8'h21 + 8'(i);
        snap();
        do_start();
        send(8, 8, 1'b0, 1'b0);
        wait_end("ovf");
        for (int i = 0; i < 6; i++) chk("ovf_mem", mem[16'h0600 + i], img[i]);
        chk("ovf_nwr", nwr - wr0, 6);
        chk("ovf_nvec", nvec - vec0, 0);
        chk("ovf_flags", {error, done, busy, cpu_reset_n, fw_ready, bus_grant}, 6'b100000);
        chk("ovf_count", byte_count, 6);

        // Reset after 3 of 5 bytes, then a clean reload
        img[0] = 8'hA9; img[1] = 8'h01; img[2] = 8'h8D; img[3] = 8'h00; img[4] = 8'h02;
        do_start();
        send(5, 3, 1'b0, 1'b0);
        chk("mid_count", byte_count, 3);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_flags", {mem_we, bus_grant, cpu_reset_n, busy, done, error, fw_ready}, 7'b0);
        chk("mid_rst_bus", {mem_addr, mem_din, byte_count}, 40'h0);
        reset = 1'b0;
        snap();
        do_start();
        send(5, 5, 1'b0, 1'b0);
        wait_end("re");
        check_load("re", 5);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
